race_arbiter_array: RTL and testbench

- Parametrised successor to the single-pair race arbiter for the delay-based PUF.
- Resolves NUM_CH delay-line races in parallel and sequences NUM_EVAL repeated evaluations per challenge.
- Majority-votes each channel's winner and flags unstable or timed-out channels.
- Sits between the delay-line fabric (drives launch and race_clr, receives fin1/fin2) and the serial response/UART logic (resp, resp_valid).

---
 rtl/race_arbiter_array.sv | 176 +++++++++++++++++
 tb/tb_race_arbiter_array.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/race_arbiter_array.sv
// Parallel race arbiter for the delay-based PUF: runs NUM_EVAL races per challenge on NUM_CH
// channels, majority-votes each channel's winner and flags unstable or timed-out channels.
module race_arbiter_array #(
  parameter int unsigned NUM_CH      = 8,
  parameter int unsigned NUM_EVAL    = 5,
  parameter int unsigned TIMEOUT     = 255,
  parameter int unsigned CLR_CYCLES  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [NUM_CH-1:0] fin1,
  input  logic [NUM_CH-1:0] fin2,
  output logic              launch,
  output logic              race_clr,
  output logic              busy,
  output logic [NUM_CH-1:0] resp,
  output logic [NUM_CH-1:0] unstable,
  output logic              timeout_err,
  output logic              resp_valid
);

  localparam int unsigned EW = $clog2(NUM_EVAL + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned CW = $clog2(CLR_CYCLES + 1);

  if ((NUM_EVAL % 2) == 0) begin : g_bad_num_eval
    $error("NUM_EVAL must be odd and at least 1");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end
  if (CLR_CYCLES < 1) begin : g_bad_clr_cycles
    $error("CLR_CYCLES must be at least 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("SYNC_STAGES must be at least 2");
  end

  typedef enum logic [2:0] {StIdle, StClear, StRace, StSample, StDone} state_e;

  state_e            state;
  logic [NUM_CH-1:0] win_l;
  logic [NUM_CH-1:0] done_l;
  logic [NUM_CH-1:0] win_sync  [SYNC_STAGES];
  logic [NUM_CH-1:0] done_sync [SYNC_STAGES];
  logic [NUM_CH-1:0] winner_s;
  logic [NUM_CH-1:0] done_s;
  logic [EW-1:0]     ones      [NUM_CH];
  logic [EW-1:0]     ones_nxt  [NUM_CH];
  logic [NUM_CH-1:0] tmo;
  logic [NUM_CH-1:0] tmo_nxt;
  logic [NUM_CH-1:0] resp_nxt;
  logic [NUM_CH-1:0] unstable_nxt;
  logic [EW-1:0]     eval_cnt;
  logic [TW-1:0]     timer;
  logic [CW-1:0]     clr_cnt;

  // Winner latch: the first finishing path is captured and held until race_clr; a tie goes to fin1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win_l  <= '0;
      done_l <= '0;
    end else if (race_clr) begin
      win_l  <= '0;
      done_l <= '0;
    end else begin
      win_l  <= win_l | (~done_l & fin1);
      done_l <= done_l | fin1 | fin2;
    end
  end

  // Clearing the chain with race_clr keeps stale results out of the next race's first cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        win_sync[k]  <= '0;
        done_sync[k] <= '0;
      end
    end else if (race_clr) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        win_sync[k]  <= '0;
        done_sync[k] <= '0;
      end
    end else begin
      win_sync[0]  <= win_l;
      done_sync[0] <= done_l;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        win_sync[k]  <= win_sync[k-1];
        done_sync[k] <= done_sync[k-1];
      end
    end
  end

  assign winner_s = win_sync[SYNC_STAGES-1];
  assign done_s   = done_sync[SYNC_STAGES-1];
  assign busy     = (state != StIdle);

  // Vote state after the current SAMPLE; a timed-out channel contributes a 0 vote.
  always_comb begin
    tmo_nxt = tmo | ~done_s;
    for (int i = 0; i < NUM_CH; i++) begin
      ones_nxt[i]     = ones[i] + EW'(done_s[i] & winner_s[i]);
      resp_nxt[i]     = (ones_nxt[i] > EW'(NUM_EVAL / 2));
      unstable_nxt[i] = tmo_nxt[i] | ((ones_nxt[i] != '0) && (ones_nxt[i] != EW'(NUM_EVAL)));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= StIdle;
      race_clr    <= 1'b1;
      launch      <= 1'b0;
      resp        <= '0;
      unstable    <= '0;
      timeout_err <= 1'b0;
      resp_valid  <= 1'b0;
      eval_cnt    <= '0;
      timer       <= '0;
      clr_cnt     <= '0;
      tmo         <= '0;
      for (int i = 0; i < NUM_CH; i++) ones[i] <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        StIdle: begin
          if (start) begin
            for (int i = 0; i < NUM_CH; i++) ones[i] <= '0;
            tmo      <= '0;
            eval_cnt <= '0;
            clr_cnt  <= '0;
            state    <= StClear;
          end
        end
        StClear: begin
          if (clr_cnt == CW'(CLR_CYCLES - 1)) begin
            timer    <= '0;
            race_clr <= 1'b0;
            launch   <= 1'b1;
            state    <= StRace;
          end else begin
            clr_cnt <= clr_cnt + CW'(1);
          end
        end
        StRace: begin
          if ((&done_s) || (timer == TW'(TIMEOUT - 1))) begin
            launch   <= 1'b0;
            race_clr <= 1'b1;
            state    <= StSample;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        StSample: begin
          for (int i = 0; i < NUM_CH; i++) ones[i] <= ones_nxt[i];
          tmo      <= tmo_nxt;
          eval_cnt <= eval_cnt + EW'(1);
          if (eval_cnt == EW'(NUM_EVAL - 1)) begin
            resp        <= resp_nxt;
            unstable    <= unstable_nxt;
            timeout_err <= |tmo_nxt;
            resp_valid  <= 1'b1;
            state       <= StDone;
          end else begin
            clr_cnt <= '0;
            state   <= StClear;
          end
        end
        StDone:  state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_race_arbiter_array.sv
// Self-checking bench for race_arbiter_array: directed scenarios plus randomized races against
// a per-challenge vote model built from the programmed path delays.
module tb_race_arbiter_array;
  localparam int unsigned NCH = 4;
  localparam int unsigned NEV = 3;
  localparam int unsigned TMO = 16;
  localparam int unsigned CLR = 4;

  logic           clk, reset_n, start;
  logic [NCH-1:0] fin1, fin2, resp, unstable;
  logic           launch, race_clr, busy, timeout_err, resp_valid;

  int             n_vec = 0;
  int             n_err = 0;
  int             cyc = 0;
  int             ev = -1;
  int             lcnt = 0;
  int             em;
  logic           prev_l = 1'b0;
  int             pulse_cnt = 0;
  int             pulse_cyc[$];
  int             race_len[$];
  logic [NCH-1:0] ws_q[$];
  int             d1[NEV][NCH];
  int             d2[NEV][NCH];
  logic [NCH-1:0] cap_resp, cap_unst, exp_resp, exp_unst;
  logic           cap_terr, exp_terr;
  int             lat, p0, acc;

  race_arbiter_array #(
    .NUM_CH(NCH), .NUM_EVAL(NEV), .TIMEOUT(TMO), .CLR_CYCLES(CLR), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .fin1(fin1), .fin2(fin2),
    .launch(launch), .race_clr(race_clr), .busy(busy), .resp(resp), .unstable(unstable),
    .timeout_err(timeout_err), .resp_valid(resp_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Delay-line model: path p of channel c rises d[p] launch cycles after launch (0 = never).
  initial begin
    fin1 = '0;
    fin2 = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        lcnt = 0; prev_l = 1'b0; fin1 = '0; fin2 = '0;
      end else begin
        if (launch && !prev_l) begin ev++; lcnt = 0; end
        if (launch) lcnt++;
        if (!launch && prev_l) begin
          race_len.push_back(lcnt);
          ws_q.push_back(dut.winner_s);
        end
        prev_l = launch;
        em = (ev < 0) ? 0 : ev % NEV;
        for (int c = 0; c < NCH; c++) begin
          fin1[c] = launch && ev >= 0 && d1[em][c] != 0 && lcnt >= d1[em][c];
          fin2[c] = launch && ev >= 0 && d2[em][c] != 0 && lcnt >= d2[em][c];
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (resp_valid) begin
      pulse_cnt++;
      pulse_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_all(input int a, input int b);
    for (int e = 0; e < NEV; e++)
      for (int c = 0; c < NCH; c++) begin d1[e][c] = a; d2[e][c] = b; end
  endtask

  function automatic int sum_len(input int from, input int n);
    int s = 0;
    for (int i = from; i < from + n; i++) s += race_len[i];
    return s;
  endfunction

  // Majority vote recomputed from the delay tables; exact ties use the observed winner_s.
  task automatic compute_exp();
    int a, b, ones;
    bit t;
    exp_terr = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      ones = 0; t = 1'b0;
      for (int e = 0; e < NEV; e++) begin
        a = d1[e][c]; b = d2[e][c];
        if (a == 0 && b == 0) t = 1'b1;
        else if (a != 0 && a == b) ones += int'(ws_q[e][c]);
        else if (b == 0 || (a != 0 && a < b)) ones++;
      end
      exp_resp[c] = (2 * ones > NEV);
      exp_unst[c] = t || (ones != 0 && ones != NEV);
      exp_terr    = exp_terr | t;
    end
  endtask

  // One challenge; with extra set, start is re-pulsed in CLEAR, RACE and SAMPLE.
  task automatic run(input bit extra);
    bit seen_r = 1'b0, seen_s = 1'b0;
    race_len.delete(); ws_q.delete(); ev = -1; p0 = pulse_cnt;
    start = 1'b1; acc = cyc; step(); start = 1'b0;
    for (int k = 1; k < 3000; k++) begin
      start = 1'b0;
      if (resp_valid) break;
      if (extra) begin
        if (k == 2) start = 1'b1;
        else if (launch && !seen_r) begin start = 1'b1; seen_r = 1'b1; end
        else if (!launch && seen_r && !seen_s) begin start = 1'b1; seen_s = 1'b1; end
      end
      step();
    end
    start = 1'b0;
    check("resp_valid_seen", resp_valid, 1);
    lat = cyc - acc;
    cap_resp = resp; cap_unst = unstable; cap_terr = timeout_err;
    check("race_count", race_len.size(), NEV);
    if (race_len.size() == NEV) check("latency", lat, NEV * (CLR + 1) + sum_len(0, NEV) + 1);
    compute_exp();
    step();
    check("valid_width", resp_valid, 0);
    check("busy_after", busy, 0);
  endtask

  initial begin
    reset_n = 1'b1; start = 1'b0; set_all(0, 0);
    #2 reset_n = 1'b0;
    repeat (3) step();
    check("rst_launch", launch, 0);
    check("rst_race_clr", race_clr, 1);
    check("rst_busy", busy, 0);
    check("rst_resp", resp, 0);
    check("rst_unstable", unstable, 0);
    check("rst_terr", timeout_err, 0);
    check("rst_valid", resp_valid, 0);
    reset_n = 1'b1;
    step();

    // Scenario 1: fin1 always first.
    set_all(3, 10);
    run(1'b0);
    check("s1_resp", cap_resp, 4'hF);
    check("s1_unst", cap_unst, 4'h0);
    check("s1_terr", cap_terr, 0);
    check("s1_pulses", pulse_cnt - p0, 1);

    // Scenario 2: channel 0 split 2:1, others fin2 first.
    set_all(10, 3);
    d1[0][0] = 3; d2[0][0] = 10;
    d1[2][0] = 3; d2[2][0] = 10;
    run(1'b0);
    check("s2_resp", cap_resp, 4'h1);
    check("s2_unst", cap_unst, 4'h1);
    check("s2_terr", cap_terr, 0);
    check("s2_model_resp", cap_resp, exp_resp);

    // Scenario 3: channel 2 never finishes.
    set_all(3, 10);
    for (int e = 0; e < NEV; e++) begin d1[e][2] = 0; d2[e][2] = 0; end
    run(1'b0);
    for (int e = 0; e < race_len.size(); e++) check("s3_race_len", race_len[e], TMO);
    check("s3_resp", cap_resp, 4'hB);
    check("s3_unst", cap_unst, 4'h4);
    check("s3_terr", cap_terr, 1);

    // Scenario 4: spurious start pulses, then start held across two challenges.
    set_all(3, 10);
    run(1'b1);
    repeat (10) step();
    check("s4_single_pulse", pulse_cnt - p0, 1);
    check("s4_idle", busy, 0);
    check("s4_resp", cap_resp, 4'hF);
    race_len.delete(); ws_q.delete(); ev = -1; p0 = pulse_cnt;
    start = 1'b1; acc = cyc;
    for (int k = 0; k < 6000; k++) begin
      step();
      if (pulse_cnt - p0 >= 2) break;
    end
    start = 1'b0;
    check("s4_two_pulses", pulse_cnt - p0, 2);
    if (pulse_cnt - p0 == 2 && race_len.size() == 2 * NEV) begin
      check("s4_first_lat", pulse_cyc[p0] - acc, NEV * (CLR + 1) + sum_len(0, NEV) + 1);
      check("s4_spacing", pulse_cyc[p0 + 1] - pulse_cyc[p0],
            NEV * (CLR + 1) + sum_len(NEV, NEV) + 2);
    end
    repeat (3) step();
    check("s4_idle_after", busy, 0);

    // Scenario 5: reset during the second race.
    set_all(3, 10);
    race_len.delete(); ws_q.delete(); ev = -1;
    start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k < 500; k++) begin
      if (ev == 1 && launch) break;
      step();
    end
    check("s5_in_race2", launch, 1);
    step();
    reset_n = 1'b0;
    #1;
    check("s5_launch", launch, 0);
    check("s5_race_clr", race_clr, 1);
    check("s5_busy", busy, 0);
    check("s5_resp", resp, 0);
    step(); step();
    reset_n = 1'b1;
    p0 = pulse_cnt;
    repeat (40) step();
    check("s5_no_valid", pulse_cnt - p0, 0);
    check("s5_idle", busy, 0);
    run(1'b0);
    check("s5_resp_after", cap_resp, 4'hF);
    check("s5_unst_after", cap_unst, 4'h0);
    check("s5_terr_after", cap_terr, 0);

    // Scenario 6: random orderings including exact ties.
    for (int n = 0; n < 8; n++) begin
      int x, g;
      for (int e = 0; e < NEV; e++)
        for (int c = 0; c < NCH; c++) begin
          x = $urandom_range(1, 6);
          g = $urandom_range(1, 4);
          case ($urandom_range(0, 2))
            0:       begin d1[e][c] = x;     d2[e][c] = x + g; end
            1:       begin d1[e][c] = x + g; d2[e][c] = x;     end
            default: begin d1[e][c] = x;     d2[e][c] = x;     end
          endcase
        end
      run(1'b0);
      for (int e = 0; e < race_len.size(); e++) check("s6_no_timeout", race_len[e] < TMO, 1);
      check("s6_resp", cap_resp, exp_resp);
      check("s6_unst", cap_unst, exp_unst);
      check("s6_terr", cap_terr, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
